uart_cmd_ctrl: RTL
==================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, maximum clk cycles allowed between bytes inside a packet.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, reset: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rx_byte, input, 8, received byte from the UART receiver cmd output.
REQ-006 SHALL have port rx_rdy, input, 1, UART receiver byte-ready flag; a level that stays high until cleared.
REQ-007 SHALL have port clr_rdy, output, 1, one-cycle pulse to the UART receiver clearing rx_rdy.
REQ-008 SHALL have port cmd_op, output, 8, opcode of the last valid packet.
REQ-009 SHALL have port cmd_data, output, 8, data byte of the last valid packet.
REQ-010 SHALL have port cmd_vld, output, 1, valid packet held for the consumer.
REQ-011 SHALL have port cmd_ack, input, 1, consumer acknowledge of cmd_vld.
REQ-012 SHALL have port err_pulse, output, 1, one-cycle pulse on a checksum or timeout error.
REQ-013 SHALL have port err_cnt, output, 8, saturating count of errors.

Function
REQ-014 SHALL frame packets as 4 bytes: SYNC_BYTE, OP, DATA, CHK, with the packet valid iff CHK == OP ^ DATA.
REQ-015 SHALL accept a byte in a cycle iff rx_rdy=1 and clr_rdy=0 (take), registering clr_rdy=1 on the next cycle only, so a single byte is never taken twice.
REQ-016 SHALL NOT take bytes in state HOLD; rx_rdy stays uncleared until HOLD exits.
REQ-017 SHALL use the states HUNT, GET_OP, GET_DATA, GET_CHK and HOLD.
REQ-018 SHALL handle HUNT as: take of SYNC_BYTE -> GET_OP; take of any other byte -> consumed, stay in HUNT, no error.
REQ-019 SHALL handle GET_OP as: take -> latch OP internally, go to GET_DATA.
REQ-020 SHALL handle GET_DATA as: take -> latch DATA internally, go to GET_CHK.
REQ-021 SHALL handle GET_CHK as: take with a good checksum -> load cmd_op/cmd_data and set cmd_vld next cycle, go to HOLD; take with a bad checksum -> err_pulse, go to HUNT, cmd_* unchanged.
REQ-022 SHALL handle HOLD as: cmd_ack=1 -> cmd_vld=0 next cycle, go to HUNT; cmd_ack while cmd_vld=0 is ignored.
REQ-023 SHALL hold cmd_op and cmd_data stable while cmd_vld=1; they retain their last value after ack.
REQ-024 SHALL count the timeout with a 16-bit counter: cleared on entry to GET_OP and on every take, incremented each cycle in GET_OP/GET_DATA/GET_CHK, and held at 0 in HUNT/HOLD.
REQ-025 SHALL, when the counter reaches TIMEOUT-1 with no take that cycle, pulse err_pulse and go to HUNT.
REQ-026 SHALL give a take priority over timeout in the same cycle.
REQ-027 SHALL latency-bound valid packets so that cmd_vld rises exactly 1 cycle after the CHK take.
REQ-028 SHALL increment err_cnt by 1 per err_pulse, saturating at 8'hFF with no wrap.
REQ-029 SHALL NOT restart on a SYNC_BYTE received mid-packet; it is treated as data.

Reset
REQ-030 SHALL, on rst=1, asynchronously force state=HUNT, clr_rdy=0, cmd_vld=0, cmd_op=8'h00, cmd_data=8'h00, err_pulse=0, err_cnt=8'h00, and timeout counter=0.
REQ-031 SHALL abandon any partial packet on reset mid-packet; after release it requires a new SYNC_BYTE.
REQ-032 SHALL, on release, take a byte already pending (rx_rdy=1) on the first clock after release.

Verification
REQ-033 SHALL cover: bytes A5,12,34,26 -> cmd_vld=1, cmd_op=12, cmd_data=34 one cycle after the 4th take; exactly 4 clr_rdy pulses.
REQ-034 SHALL cover: bytes A5,12,34,00 -> err_pulse once, err_cnt=1, cmd_vld stays 0, state HUNT.
REQ-035 SHALL cover: bytes 00,FF,A5,01,02,03 -> 00/FF discarded without error; packet OP=01, DATA=02 valid.
REQ-036 SHALL cover, with TIMEOUT=16: A5,07 then idle -> err_pulse 16 cycles after the 07 take; a following A5,01,01,00 is accepted.
REQ-037 SHALL cover: a valid packet with cmd_ack held 0 for 100 cycles while rx_rdy=1 -> no clr_rdy, cmd_* stable; cmd_ack=1 -> cmd_vld=0 next cycle, pending byte taken after that.
REQ-038 SHALL cover: 256 bad packets -> err_cnt=FF and held at FF; rst pulse after A5,12 -> all outputs at reset values, and a following 34,26 is ignored.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Command packet framer behind a UART receiver: SYNC, OP, DATA, CHK (OP ^ DATA).
// Holds each valid command until acknowledged and counts checksum/timeout errors.
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_rdy,
    output logic       clr_rdy,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_data,
    output logic       cmd_vld,
    input  logic       cmd_ack,
    output logic       err_pulse,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        HUNT,
        GET_OP,
        GET_DATA,
        GET_CHK,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        clr_rdy_q, clr_rdy_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  data_q, data_d;

    logic take;
    logic timed_out;
    logic err;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The clr_rdy pulse blocks a second take of the byte the receiver is still clearing.
    assign take      = rx_rdy && !clr_rdy_q && (state_q != HOLD);
    assign timed_out = (to_cnt_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d     = state_q;
        clr_rdy_d   = take;
        cmd_op_d    = cmd_op_q;
        cmd_data_d  = cmd_data_q;
        cmd_vld_d   = cmd_vld_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        to_cnt_d    = 16'd0;
        op_d        = op_q;
        data_d      = data_q;
        err         = 1'b0;

        case (state_q)
            HUNT: begin
                if (take && (rx_byte == SYNC_BYTE)) state_d = GET_OP;
            end
            GET_OP: begin
                if (take) begin
                    op_d    = rx_byte;
                    state_d = GET_DATA;
                end else if (timed_out) begin
                    err     = 1'b1;
                    state_d = HUNT;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            GET_DATA: begin
                if (take) begin
                    data_d  = rx_byte;
                    state_d = GET_CHK;
                end else if (timed_out) begin
                    err     = 1'b1;
                    state_d = HUNT;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            GET_CHK: begin
                if (take) begin
                    if (rx_byte == (op_q ^ data_q)) begin
                        cmd_op_d   = op_q;
                        cmd_data_d = data_q;
                        cmd_vld_d  = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end
                end else if (timed_out) begin
                    err     = 1'b1;
                    state_d = HUNT;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (cmd_ack && cmd_vld_q) begin
                    cmd_vld_d = 1'b0;
                    state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (err) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            clr_rdy_q   <= 1'b0;
            cmd_op_q    <= 8'h00;
            cmd_data_q  <= 8'h00;
            cmd_vld_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'h00;
            to_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            clr_rdy_q   <= clr_rdy_d;
            cmd_op_q    <= cmd_op_d;
            cmd_data_q  <= cmd_data_d;
            cmd_vld_q   <= cmd_vld_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Packet scratch bytes are only read after being written in the same packet.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        data_q <= data_d;
    end

    assign clr_rdy   = clr_rdy_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_vld   = cmd_vld_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
